// File: rtl/serial_operand_alu.sv
// serial_operand_alu: collects 2*WIDTH/8 bytes from a UART receive strobe,
// bit-serialises each byte MSB first into a 2*WIDTH-bit window, applies the
// ALU op latched with the first byte and offers the result over valid/ready.
// Optional build macro: SERIAL_ALU_SATURATE_EN (saturating ADD/SUB results).
module serial_operand_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       RX_BYTE,
    input  logic             RX_VALID,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] RESULT,
    output logic             RESULT_VALID,
    input  logic             RESULT_READY,
    output logic             CARRY,
    output logic             BUSY,
    output logic             OVERRUN,
    output logic [1:0]       DBG
);

    localparam int NBYTES = WIDTH / 8;
    localparam int NOPB   = 2 * NBYTES;
    localparam int CW     = $clog2(NOPB + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NOPB - 1);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_SHIFT   = 2'd1,
        S_COMPUTE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_XOR = 2'd2,
        OP_AND = 2'd3
    } op_t;

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_window;
    logic [7:0]           r_piso;
    logic [2:0]           r_bit_cnt;
    logic [CW-1:0]        r_byte_cnt;
    op_t                  r_mode;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry;
    logic                 r_overrun;

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_carry;
    logic                 w_drop;

    assign w_a    = r_window[2*WIDTH-1:WIDTH];
    assign w_b    = r_window[WIDTH-1:0];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};
    assign w_drop = RX_VALID && (r_state != S_WAIT);

    assign RESULT       = r_result;
    assign CARRY        = r_carry;
    assign OVERRUN      = r_overrun;
    assign RESULT_VALID = (r_state == S_HOLD);
    assign BUSY         = (r_state != S_WAIT);
    assign DBG          = r_window[1:0];

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (RX_VALID) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_bit_cnt == 3'd7) begin
                    w_next = (r_byte_cnt == LAST_BYTE) ? S_COMPUTE : S_WAIT;
                end
            end
            S_COMPUTE: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (RESULT_READY) begin
                    w_next = S_WAIT;
                end
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

    // ALU on the two window halves; raw carry/borrow always reported
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (r_mode)
            OP_ADD: begin
                w_alu_carry = w_sum[WIDTH];
`ifdef SERIAL_ALU_SATURATE_EN
                w_alu_res   = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
                w_alu_res   = w_sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                w_alu_carry = w_diff[WIDTH];
`ifdef SERIAL_ALU_SATURATE_EN
                w_alu_res   = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
                w_alu_res   = w_diff[WIDTH-1:0];
`endif
            end
            OP_XOR: begin
                w_alu_res = w_a ^ w_b;
            end
            OP_AND: begin
                w_alu_res = w_a & w_b;
            end
            default: begin
                w_alu_res = '0;
            end
        endcase
    end

    // Datapath: byte capture, serial shift, result register, overrun flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_window   <= '0;
            r_piso     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_mode     <= OP_ADD;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_WAIT: begin
                    if (RX_VALID) begin
                        r_piso    <= RX_BYTE;
                        r_bit_cnt <= '0;
                        if (r_byte_cnt == '0) begin
                            r_mode <= op_t'(MODE);
                        end
                    end
                end
                S_SHIFT: begin
                    r_window  <= {r_window[2*WIDTH-2:0], r_piso[7]};
                    r_piso    <= {r_piso[6:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                end
                S_COMPUTE: begin
                    r_result   <= w_alu_res;
                    r_carry    <= w_alu_carry;
                    r_byte_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
